// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one op per handshake, single-cycle logic ops,
// iterative one-bit-per-cycle shifts, branch compare and squash support.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_taken,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [SW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] acc, acc_n, sh1;
  logic [3:0]       sop;
  logic [TAG_W-1:0] stag;
  logic [SW-1:0]    shamt;
  logic             is_sh, take, out_free;
  logic [WIDTH-1:0] res;
  logic             tk, lt;
  logic             load, load_tk;
  logic [WIDTH-1:0] load_res;
  logic [TAG_W-1:0] load_tag;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == IDLE) && out_free && !flush;
  assign take     = in_valid && in_ready;
  assign shamt    = in_b[SW-1:0];
  assign lt       = $signed(in_a) < $signed(in_b);
  assign is_sh    = (in_op == 4'b0011) || (in_op == 4'b0100)
                 || (in_op == 4'b0110);

  always_comb begin
    res = '0;
    tk  = 1'b0;
    case (in_op)
      4'b0000: res = in_a & in_b;
      4'b0001: res = in_a | in_b;
      4'b0010: res = in_a + in_b;
      4'b0101: res = in_a - in_b;
      4'b0111: res = {{(WIDTH-1){1'b0}}, lt};
      4'b1100: res = in_a ^ in_b;
      4'b1101: res = in_b;
      4'b1000: tk  = in_a == in_b;
      4'b1001: tk  = in_a != in_b;
      4'b1010: tk  = lt;
      4'b1011: tk  = !lt;
      // zero-amount shifts complete immediately
      4'b0011, 4'b0100, 4'b0110: res = in_a;
      default: res = '0;
    endcase
  end

  always_comb begin
    unique case (1'b1)
      (sop == 4'b0011): sh1 = {acc[WIDTH-2:0], 1'b0};
      (sop == 4'b0100): sh1 = {1'b0, acc[WIDTH-1:1]};
      default:          sh1 = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    acc_n    = acc;
    load     = 1'b0;
    load_res = res;
    load_tk  = tk;
    load_tag = in_tag;
    case (state)
      IDLE: begin
        if (take) begin
          if (is_sh && shamt != '0) begin
            state_n = SHIFT;
            cnt_n   = shamt;
            acc_n   = in_a;
          end else begin
            load = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          acc_n = sh1;
          cnt_n = cnt - 1'b1;
        end
        // finish now, or park at cnt==0 until the output frees
        if (cnt <= SW'(1) && out_free) begin
          load     = 1'b1;
          load_res = (cnt != '0) ? sh1 : acc;
          load_tk  = 1'b0;
          load_tag = stag;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      sop        <= '0;
      stag       <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_taken  <= 1'b0;
      out_tag    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      acc   <= acc_n;
      if (take) begin
        sop  <= in_op;
        stag <= in_tag;
      end
      if (load) begin
        out_valid  <= 1'b1;
        out_result <= load_res;
        out_taken  <= load_tk;
        out_tag    <= load_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed plan steps then random ops
// against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_taken;
  logic [4:0]  out_tag;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_taken(out_taken),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
    end
  endtask

  // {taken, result}
  function automatic logic [32:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        k;
    int          sa;
    sa = int'(b % 32);
    r  = 0;
    k  = 0;
    case (op)
      0:  r = a & b;
      1:  r = a | b;
      2:  r = a + b;
      3:  r = a << sa;
      4:  r = a >> sa;
      5:  r = a - b;
      6:  r = $signed(a) >>> sa;
      7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      12: r = a ^ b;
      13: r = b;
      8:  k = (a == b);
      9:  k = (a != b);
      10: k = ($signed(a) < $signed(b));
      11: k = ($signed(a) >= $signed(b));
      default: r = 0;
    endcase
    return {k, r};
  endfunction

  function automatic int ref_lat(input logic [3:0] op,
                                 input logic [31:0] b);
    if ((op == 3 || op == 4 || op == 6) && (b % 32) != 0)
      return int'(b % 32) + 1;
    return 1;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tg);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tg;
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic accept_wait(input string t);
    int n;
    n = 0;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({t, "_accept"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg,
                        input bit bp);
    logic [32:0] e;
    int          n;
    bit          r;
    e = ref_alu(op, a, b);
    out_ready = 1'b1;
    drive(op, a, b, tg);
    accept_wait("op");
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n + 1, ref_lat(op, b));
    n = 0;
    do begin
      chk("result", out_result, e[31:0]);
      chk("taken", out_taken, e[32]);
      chk("tag", out_tag, tg);
      r = bp ? bit'($urandom_range(0, 1)) : 1'b1;
      if (n > 6) r = 1'b1;
      out_ready = r;
      @(negedge clk);
      n++;
    end while (!r);
    chk("drained", out_valid, 0);
  endtask

  initial begin
    int n;
    logic [3:0]  op;
    logic [31:0] a, b;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_taken", out_taken, 0);
    chk("rst_tag", out_tag, 0);
    rst_n = 1'b1;
    @(negedge clk);

    out_ready = 1'b1;
    drive(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd5);
    accept_wait("add");
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 32'h8000_0000);
    chk("add_tag", out_tag, 5);
    chk("add_taken", out_taken, 0);
    @(negedge clk);
    chk("add_consumed", out_valid, 0);

    drive(4'b0110, 32'h8000_0000, 32'h0000_0104, 5'd3);
    accept_wait("sra");
    for (int k = 1; k <= 4; k++) begin
      chk("sra_busy_ready", in_ready, 0);
      chk("sra_busy_valid", out_valid, 0);
      @(negedge clk);
    end
    chk("sra_valid", out_valid, 1);
    chk("sra_result", out_result, 32'hF800_0000);
    chk("sra_tag", out_tag, 3);
    @(negedge clk);

    drive(4'b1010, 32'hFFFF_FFFF, 32'd1, 5'd7);
    accept_wait("blt");
    chk("blt_taken", out_taken, 1);
    chk("blt_result", out_result, 0);
    drive(4'b1011, 32'hFFFF_FFFF, 32'd1, 5'd8);
    accept_wait("bge");
    chk("bge_valid", out_valid, 1);
    chk("bge_taken", out_taken, 0);
    @(negedge clk);

    out_ready = 1'b0;
    drive(4'b0101, 32'd10, 32'd3, 5'd9);
    accept_wait("sub");
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_result", out_result, 7);
      chk("bp_tag", out_tag, 9);
      chk("bp_ready", in_ready, 0);
      @(negedge clk);
    end
    drive(4'b1100, 32'hF0, 32'hFF, 5'd10);
    out_ready = 1'b1;
    accept_wait("xor");
    chk("xor_valid", out_valid, 1);
    chk("xor_result", out_result, 32'h0F);
    chk("xor_tag", out_tag, 10);
    @(negedge clk);

    drive(4'b0011, 32'd1, 32'd20, 5'd11);
    accept_wait("sll");
    repeat (6) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("post_flush_ready", in_ready, 1);
    chk("post_flush_valid", out_valid, 0);
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("flushed_never_valid", n, 0);
    run_op(4'b0010, 32'd1, 32'd1, 5'd12, 1'b0);

    drive(4'b0010, 32'd4, 32'd4, 5'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_blocks_accept", out_valid, 0);

    drive(4'b0011, 32'hA5A5_A5A5, 32'd10, 5'd13);
    accept_wait("sll_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_result", out_result, 0);
    chk("arst_tag", out_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("no_stale_result", n, 0);

    for (int k = 0; k < 16; k++)
      run_op(4'(k), 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'(k), 1'b0);

    for (int k = 0; k < 150; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      run_op(op, a, b, 5'($urandom_range(0, 31)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
